// File: rtl/lib_pkg.sv
// Shared fetch-path types and constants.
package lib_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          PC_W      = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush; head is the oldest entry, count is the occupancy.
module fetch_queue #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = lib_pkg::fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy alone decides what is valid, so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited memory requests, in-order
// response queue to decode, and redirect handling with stale-response discard.
module fetch_unit import lib_pkg::*; #(
  parameter int             XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int             QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int          CW     = $clog2(QDEPTH+1);
  localparam logic [CW:0] CREDIT = (CW+1)'(QDEPTH);

  typedef logic [XLEN-1:0] addr_t;
  typedef struct packed {
    addr_t       pc;
    logic [31:0] instr;
  } entry_t;

  addr_t         pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] q_count, a_count;
  entry_t        q_head, q_push_data;
  addr_t         a_head;
  logic          accept, resp, q_push, q_pop;

  // Credit counts both outstanding requests and queued entries, so every response has a slot.
  assign imem_req_valid = rst_n && !stall_f && !redirect &&
                          (({1'b0, inflight_q} + {1'b0, q_count}) < CREDIT);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response with no recorded address is a leftover from before reset.
  assign resp        = imem_resp_valid && (a_count != '0);
  assign q_push      = resp && (drop_q == '0) && !redirect;
  assign q_pop       = if_valid && !stall_d && !redirect;
  assign q_push_data = '{pc: a_head, instr: imem_resp_data};

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + CW'(accept) - CW'(resp);
    drop_d     = drop_q;
    if (accept) pc_d = pc_q + addr_t'(4);
    if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect) begin
      pc_d   = redirect_pc;
      drop_d = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .entry_t(entry_t)) u_instr_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .count_o     (q_count)
  );

  // Addresses of outstanding requests; never flushed because stale responses still return.
  fetch_queue #(.DEPTH(QDEPTH), .entry_t(addr_t)) u_addr_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (1'b0),
    .push_i      (accept),
    .push_data_i (pc_q),
    .pop_i       (resp),
    .head_o      (a_head),
    .count_o     (a_count)
  );

  always_comb begin
    if_valid = (q_count != '0);
    if_instr = NOP_INSTR;
    if_pc    = '0;
    if (if_valid) begin
      if_instr = q_head.instr;
      if_pc    = q_head.pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// whose responses can be held back to build up in-flight requests.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall_f, stall_d, redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;

  logic        hold;
  logic [31:0] pend[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: remembers accepted addresses, answers oldest first.
  always @(posedge clk) begin
    if (imem_resp_valid && pend.size() > 0) pend.delete(0);
    if (imem_req_valid && imem_req_ready) pend.push_back(imem_req_addr);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input logic sf, input logic sd, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    imem_resp_valid = !hold && (pend.size() > 0);
    imem_resp_data  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
    stall_f     = sf;
    stall_d     = sd;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    stall_f = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_if_valid",  if_valid, 0);
    check("rst_if_instr",  if_instr, NOP);
    check("rst_if_pc",     if_pc, 0);
    check("rst_req_addr",  imem_req_addr, 0);
    @(posedge clk); #1 rst_n = 1'b1; #1;

    // Streaming, 1-cycle memory
    check("s_req_valid0", imem_req_valid, 1);
    check("s_addr0",      imem_req_addr, 32'h0);
    check("s_no_bypass",  if_valid, 0);
    cyc(0, 0, 0, 0);
    check("s_addr4",      imem_req_addr, 32'h4);
    check("s_req_valid4", imem_req_valid, 1);
    check("s_lat_1",      if_valid, 0);
    cyc(0, 0, 0, 0);
    check("s_if_valid0",  if_valid, 1);
    check("s_if_pc0",     if_pc, 32'h0);
    check("s_if_instr0",  if_instr, 32'hA000_0000);
    check("s_addr8",      imem_req_addr, 32'h8);
    check("s_req_valid8", imem_req_valid, 1);
    cyc(0, 0, 0, 0);
    check("s_if_pc4",     if_pc, 32'h4);
    check("s_if_instr4",  if_instr, 32'hA000_0004);
    check("s_addrC",      imem_req_addr, 32'hC);

    // stall_f: no requests, PC held at 0x10, decode keeps draining
    cyc(1, 0, 0, 0);
    check("sf_req0",   imem_req_valid, 0);
    check("sf_addr0",  imem_req_addr, 32'h10);
    check("sf_if_pc0", if_pc, 32'h8);
    cyc(1, 0, 0, 0);
    check("sf_req1",   imem_req_valid, 0);
    check("sf_addr1",  imem_req_addr, 32'h10);
    check("sf_if_pc1", if_pc, 32'hC);
    cyc(0, 0, 0, 0);
    check("sf_resume_req",  imem_req_valid, 1);
    check("sf_resume_addr", imem_req_addr, 32'h10);
    check("sf_drained",     if_valid, 0);

    // stall_d fills the queue until credit runs out
    cyc(0, 1, 0, 0);
    check("sd_addr14", imem_req_addr, 32'h14);
    check("sd_req14",  imem_req_valid, 1);
    cyc(0, 1, 0, 0);
    check("sd_if_pc_a", if_pc, 32'h10);
    check("sd_addr18",  imem_req_addr, 32'h18);
    cyc(0, 1, 0, 0);
    check("sd_addr1C",  imem_req_addr, 32'h1C);
    check("sd_req1C",   imem_req_valid, 1);
    cyc(0, 1, 0, 0);
    check("sd_no_credit", imem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check("sd_full_req",   imem_req_valid, 0);
      check("sd_full_if_pc", if_pc, 32'h10);
      check("sd_full_valid", if_valid, 1);
    end
    cyc(0, 0, 0, 0);
    check("sd_rel_if_pc", if_pc, 32'h10);
    check("sd_rel_req",   imem_req_valid, 0);
    hold = 1'b1;
    cyc(0, 0, 0, 0);
    check("sd_pop_14",  if_pc, 32'h14);
    check("sd_addr20",  imem_req_addr, 32'h20);
    check("sd_req20",   imem_req_valid, 1);
    cyc(0, 0, 0, 0);
    check("sd_pop_18",  if_pc, 32'h18);
    check("sd_addr24",  imem_req_addr, 32'h24);

    // Redirect with 0x20/0x24 still in flight
    cyc(0, 0, 1, 32'h100);
    check("rd_req_blocked", imem_req_valid, 0);
    check("rd_head_1C",     if_pc, 32'h1C);
    hold = 1'b0;
    cyc(0, 0, 0, 0);
    check("rd_flushed",  if_valid, 0);
    check("rd_addr100",  imem_req_addr, 32'h100);
    check("rd_req100",   imem_req_valid, 1);
    cyc(0, 0, 0, 0);
    check("rd_drop20", if_valid, 0);
    cyc(0, 0, 0, 0);
    check("rd_drop24", if_valid, 0);

    // First correct-path delivery, while a new redirect collides with a response
    cyc(0, 0, 1, 32'h200);
    check("rd_first_pc",    if_pc, 32'h100);
    check("rd_first_instr", if_instr, 32'hA000_0100);
    check("rd2_req_blocked", imem_req_valid, 0);
    cyc(0, 0, 0, 0);
    check("rd2_flushed",   if_valid, 0);
    check("rd2_addr200",   imem_req_addr, 32'h200);
    cyc(0, 0, 0, 0);
    check("rd2_drop108",   if_valid, 0);
    cyc(0, 0, 0, 0);
    check("rd2_first_pc",    if_pc, 32'h200);
    check("rd2_first_instr", if_instr, 32'hA000_0200);

    // Reset mid-stream with two requests outstanding
    hold = 1'b1;
    cyc(0, 0, 0, 0);
    check("mr_pre_pc",   if_pc, 32'h204);
    check("mr_pre_addr", imem_req_addr, 32'h20C);
    cyc(0, 0, 0, 0);
    rst_n = 1'b0; #1;
    check("mr_req_valid", imem_req_valid, 0);
    check("mr_if_valid",  if_valid, 0);
    check("mr_if_instr",  if_instr, NOP);
    check("mr_if_pc",     if_pc, 0);
    check("mr_addr",      imem_req_addr, 32'h0);
    hold = 1'b0;
    cyc(1, 0, 0, 0);
    rst_n = 1'b1; #1;
    cyc(1, 0, 0, 0);
    check("mr_late_a", if_valid, 0);
    cyc(1, 0, 0, 0);
    check("mr_late_b",  if_valid, 0);
    check("mr_stall_f", imem_req_valid, 0);
    cyc(0, 0, 0, 0);
    check("mr_req0",  imem_req_valid, 1);
    check("mr_addr0", imem_req_addr, 32'h0);
    cyc(0, 0, 0, 0);
    check("mr_lat", if_valid, 0);
    cyc(0, 0, 0, 0);
    check("mr_if_pc0",    if_pc, 32'h0);
    check("mr_if_instr0", if_instr, 32'hA000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
